// File: rtl/ro_puf_eval_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : ro_puf_eval_ctrl_if
// Purpose   : Bundle of the challenge/response handshake, oscillator drive
//             and debug count signals of the RO-PUF evaluation sequencer.
//             master = requester / oscillator array side,
//             slave  = sequencer side.
// Revision  : 1.0 - initial release
// ============================================================================
interface ro_puf_eval_ctrl_if #(
  parameter int NBITS = 8,
  parameter int SEL_W = 4,
  parameter int CNT_W = 16
);

  // Request side
  logic                 start;
  logic [2*SEL_W-1:0]   challenge;
  // Oscillator array
  logic                 ro_a;
  logic                 ro_b;
  logic                 ro_en;
  logic [SEL_W-1:0]     sel_a;
  logic [SEL_W-1:0]     sel_b;
  // Status and response
  logic                 busy;
  logic [NBITS-1:0]     resp;
  logic                 resp_valid;
  logic                 resp_ready;
  // Debug counts
  logic [CNT_W-1:0]     cnt_a_last;
  logic [CNT_W-1:0]     cnt_b_last;

  modport master (
    output start, challenge, ro_a, ro_b, resp_ready,
    input  ro_en, sel_a, sel_b, busy, resp, resp_valid, cnt_a_last, cnt_b_last
  );

  modport slave (
    input  start, challenge, ro_a, ro_b, resp_ready,
    output ro_en, sel_a, sel_b, busy, resp, resp_valid, cnt_a_last, cnt_b_last
  );

endinterface
`default_nettype wire

// File: rtl/ro_puf_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ro_puf_eval_ctrl
// Purpose  : Ring-oscillator PUF evaluation sequencer. For each of NBITS
//            oscillator pairs it enables the array, lets it settle, counts
//            synchronized rising edges of both oscillators over a fixed
//            window and records (count_a > count_b) as one response bit.
// Revision : 1.0 - initial release
// ============================================================================
module ro_puf_eval_ctrl #(
  parameter int NBITS  = 8,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  ro_puf_eval_ctrl_if.slave ctrl_if
);

  // Phase timer only has to hold (longest phase - 1).
  localparam int TMAX = (WINDOW > SETTLE) ? ((WINDOW > GAP) ? WINDOW : GAP)
                                          : ((SETTLE > GAP) ? SETTLE : GAP);
  localparam int TW   = $clog2(TMAX);
  localparam int IW   = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [TW-1:0]    T_SETTLE = TW'(SETTLE - 1);
  localparam logic [TW-1:0]    T_WINDOW = TW'(WINDOW - 1);
  localparam logic [TW-1:0]    T_GAP    = TW'(GAP - 1);
  localparam logic [IW-1:0]    LAST_IDX = IW'(NBITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_COMPARE = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [2*SEL_W-1:0]   chal_q, chal_d;
  logic                 load_sel;
  logic [SEL_W-1:0]     pair_a, pair_b;
  logic [SEL_W-1:0]     sel_a_q, sel_a_d;
  logic [SEL_W-1:0]     sel_b_q, sel_b_d;
  logic [NBITS-1:0]     resp_q, resp_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [CNT_W-1:0]     cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]     cnt_b_q, cnt_b_d;
  logic [CNT_W-1:0]     cnt_a_last_q, cnt_a_last_d;
  logic [CNT_W-1:0]     cnt_b_last_q, cnt_b_last_d;
  logic [2:0]           sync_a_q, sync_b_q;
  logic                 rise_a, rise_b;

  // --------------------------------------------------------------------------
  // Oscillator inputs: bits [1:0] form the two-flop synchronizer, bit [2] is
  // the history flop used for rising-edge detection.
  // --------------------------------------------------------------------------
  // Shift raw oscillator levels into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[1:0], ctrl_if.ro_a};
      sync_b_q <= {sync_b_q[1:0], ctrl_if.ro_b};
    end
  end

  assign rise_a = sync_a_q[1] & ~sync_a_q[2];
  assign rise_b = sync_b_q[1] & ~sync_b_q[2];

  // Edge counters: cleared while settling, saturating count while measuring.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (state_q == S_SETTLE) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else if (state_q == S_MEASURE) begin
      if (rise_a && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + CNT_W'(1);
      if (rise_b && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer next-state logic
  // --------------------------------------------------------------------------
  // Phase sequencing, challenge capture, response bit and debug count update.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    idx_d        = idx_q;
    chal_d       = chal_q;
    resp_d       = resp_q;
    resp_valid_d = 1'b0;
    cnt_a_last_d = cnt_a_last_q;
    cnt_b_last_d = cnt_b_last_q;
    load_sel     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctrl_if.start) begin
          chal_d   = ctrl_if.challenge;
          idx_d    = '0;
          resp_d   = '0;
          timer_d  = T_SETTLE;
          load_sel = 1'b1;
          state_d  = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (timer_q == '0) begin
          timer_d = T_WINDOW;
          state_d = S_MEASURE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_MEASURE: begin
        if (timer_q == '0) begin
          state_d = S_COMPARE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_COMPARE: begin
        // A tie yields 0 so equal oscillators never bias towards 1.
        resp_d[idx_q] = (cnt_a_q > cnt_b_q);
        cnt_a_last_d  = cnt_a_q;
        cnt_b_last_d  = cnt_b_q;
        timer_d       = T_GAP;
        state_d       = S_GAP;
      end

      S_GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d    = idx_q + IW'(1);
          timer_d  = T_SETTLE;
          load_sel = 1'b1;
          state_d  = S_SETTLE;
        end
      end

      S_DONE: begin
        // Valid is registered, so it appears one cycle after entering DONE
        // and clears on the same edge the handshake returns us to IDLE.
        if (resp_valid_q && ctrl_if.resp_ready) begin
          state_d = S_IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pair selects for the pair being entered; B is nudged off A on collision.
  always_comb begin
    pair_a = chal_d[SEL_W-1:0] + SEL_W'(idx_d);
    pair_b = chal_d[2*SEL_W-1:SEL_W] + SEL_W'(idx_d);
    if (pair_b == pair_a) pair_b = pair_a ^ SEL_W'(1);
  end

  // Selects only change on entry to SETTLE and stay put through GAP.
  always_comb begin
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    if (load_sel) begin
      sel_a_d = pair_a;
      sel_b_d = pair_b;
    end
  end

  // Sequencer and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      idx_q        <= '0;
      chal_q       <= '0;
      sel_a_q      <= '0;
      sel_b_q      <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      cnt_a_last_q <= '0;
      cnt_b_last_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      chal_q       <= chal_d;
      sel_a_q      <= sel_a_d;
      sel_b_q      <= sel_b_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
      cnt_a_last_q <= cnt_a_last_d;
      cnt_b_last_q <= cnt_b_last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The enable decodes the state register directly so it falls the
  // instant reset is asserted, without waiting for a clock edge.
  // --------------------------------------------------------------------------
  assign ctrl_if.ro_en      = (state_q == S_SETTLE) || (state_q == S_MEASURE);
  assign ctrl_if.busy       = (state_q != S_IDLE);
  assign ctrl_if.sel_a      = sel_a_q;
  assign ctrl_if.sel_b      = sel_b_q;
  assign ctrl_if.resp       = resp_q;
  assign ctrl_if.resp_valid = resp_valid_q;
  assign ctrl_if.cnt_a_last = cnt_a_last_q;
  assign ctrl_if.cnt_b_last = cnt_b_last_q;

endmodule
`default_nettype wire
